// File: rtl/reg_bus_datapath.sv
// Register-file bus datapath: one command at a time moves, adds, subtracts or clears
// between the IN port, NREG general registers and the OUT holding register.
module reg_bus_datapath #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SELW-1:0] cmd_src,
    input  logic [SELW-1:0] cmd_dst,
    input  logic [1:0]      cmd_op,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            flag_z,
    output logic            flag_c,
    output logic            err,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, WAIT_IN, EXEC, WAIT_OUT} state_t;

    localparam logic [1:0]      OP_MOVE  = 2'b00;
    localparam logic [1:0]      OP_ADD   = 2'b01;
    localparam logic [1:0]      OP_SUB   = 2'b10;
    localparam logic [1:0]      OP_CLEAR = 2'b11;
    localparam logic [SELW-1:0] SEL_MAX  = SELW'(NREG);

    state_t          state_q, state_d;
    logic [SELW-1:0] src_q, src_d, dst_q, dst_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   opnd_q, opnd_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            flag_z_q, flag_z_d;
    logic            flag_c_q, flag_c_d;
    logic            err_q, err_d;
    logic [DW-1:0]   s_val, d_val;
    logic [DW:0]     alu_res;

    // MSB of the result is carry-out for ADD and borrow for SUB, zero otherwise.
    function automatic logic [DW:0] alu(input logic [1:0] op, input logic [DW-1:0] d,
                                        input logic [DW-1:0] s);
        case (op)
            OP_MOVE: alu = {1'b0, s};
            OP_ADD:  alu = {1'b0, d} + {1'b0, s};
            OP_SUB:  alu = {1'b0, d} - {1'b0, s};
            default: alu = '0;
        endcase
    endfunction

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign in_ready  = (state_q == WAIT_IN) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        regs_d      = regs_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        err_d       = err_q;

        s_val = opnd_q;
        d_val = out_data_q;
        for (int k = 0; k < NREG; k++) begin
            if (src_q == SELW'(k + 1)) s_val = regs_q[k];
            if (dst_q == SELW'(k + 1)) d_val = regs_q[k];
        end
        alu_res = alu(op_q, d_val, s_val);

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    // An illegal select is swallowed here and never reaches EXEC.
                    if (cmd_src > SEL_MAX || cmd_dst > SEL_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        src_d   = cmd_src;
                        dst_d   = cmd_dst;
                        op_d    = cmd_op;
                        state_d = (cmd_src == '0 && cmd_op != OP_CLEAR) ? WAIT_IN : EXEC;
                    end
                end
            end
            WAIT_IN: begin
                if (in_valid && in_ready) begin
                    opnd_d  = in_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                flag_z_d = (alu_res[DW-1:0] == '0);
                flag_c_d = alu_res[DW];
                if (dst_q == '0) begin
                    out_data_d  = alu_res[DW-1:0];
                    out_valid_d = 1'b1;
                    state_d     = WAIT_OUT;
                end else begin
                    for (int k = 0; k < NREG; k++) begin
                        if (dst_q == SELW'(k + 1)) regs_d[k] = alu_res[DW-1:0];
                    end
                    state_d = IDLE;
                end
            end
            WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    // Latched command fields and captured IN operand are only read after acceptance.
    always_ff @(posedge clk) begin
        src_q  <= src_d;
        dst_q  <= dst_d;
        op_q   <= op_d;
        opnd_q <= opnd_d;
    end
endmodule

// File: tb/tb_reg_bus_datapath.sv
// Directed bench for reg_bus_datapath: OUT-port results checked by a scoreboard monitor,
// flags and handshakes checked inline.
module tb_reg_bus_datapath;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_src = '0;
    logic [2:0] cmd_dst = '0;
    logic [1:0] cmd_op = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_rdy = 1'b1;
    logic       flag_z, flag_c, err, busy;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] exp_q[$];

    localparam logic [1:0] MOVE = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

    always #5 clk = ~clk;

    reg_bus_datapath #(.DW(8), .NREG(4), .SELW(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_op(cmd_op),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_rdy),
        .flag_z(flag_z), .flag_c(flag_c), .err(err), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Scoreboard monitor: every OUT handshake pops one expected value.
    always @(negedge clk) begin
        logic [7:0] e;
        #1;
        if (!rst && out_valid && out_rdy) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL out_unexpected: got %0h expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e});
            end
        end
    end

    task automatic issue(input logic [2:0] s, input logic [2:0] d, input logic [1:0] op);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout("cmd_ready");
        cmd_src   = s;
        cmd_dst   = d;
        cmd_op    = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed_in(input logic [7:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("in_ready");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout("idle");
    endtask

    task automatic run(input logic [2:0] s, input logic [2:0] d, input logic [1:0] op,
                       input logic has_in, input logic [7:0] v);
        issue(s, d, op);
        if (has_in) feed_in(v);
        wait_idle();
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {err, flag_z, flag_c}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // MOVE IN -> R0
        run(3'd0, 3'd1, MOVE, 1'b1, 8'h3C);
        chk("mv_flag_z", flag_z, 0);
        chk("mv_flag_c", flag_c, 0);
        chk("mv_busy", busy, 0);
        exp_q.push_back(8'h3C);
        run(3'd1, 3'd0, MOVE, 1'b0, 8'h00);

        // ADD with carry, then SUB same register
        run(3'd0, 3'd1, MOVE, 1'b1, 8'hF0);
        run(3'd0, 3'd2, MOVE, 1'b1, 8'h20);
        run(3'd2, 3'd1, ADD, 1'b0, 8'h00);
        chk("add_flag_c", flag_c, 1);
        chk("add_flag_z", flag_z, 0);
        exp_q.push_back(8'h10);
        run(3'd1, 3'd0, MOVE, 1'b0, 8'h00);
        run(3'd1, 3'd1, SUB, 1'b0, 8'h00);
        chk("sub_flag_z", flag_z, 1);
        chk("sub_flag_c", flag_c, 0);
        exp_q.push_back(8'h00);
        run(3'd1, 3'd0, MOVE, 1'b0, 8'h00);

        // OUT back-pressure
        run(3'd0, 3'd1, MOVE, 1'b1, 8'h5A);
        out_rdy = 1'b0;
        exp_q.push_back(8'h5A);
        issue(3'd1, 3'd0, MOVE);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 8'h5A);
            chk("bp_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_cmd_ready_back", cmd_ready, 1);
        chk("bp_out_retained", out_data, 8'h5A);

        // ADD into OUT uses out_data as D
        exp_q.push_back(8'hB4);
        run(3'd1, 3'd0, ADD, 1'b0, 8'h00);
        chk("addout_flag_c", flag_c, 0);
        chk("addout_flag_z", flag_z, 0);

        // Illegal selects
        run(3'd1, 3'd1, SUB, 1'b0, 8'h00);
        chk("pre_ill_flag_z", flag_z, 1);
        issue(3'd7, 3'd1, MOVE);
        chk("ill_err", err, 1);
        chk("ill_cmd_ready", cmd_ready, 1);
        chk("ill_busy", busy, 0);
        chk("ill_flag_z", flag_z, 1);
        repeat (2) @(negedge clk);
        chk("ill_err_sticky", err, 1);
        issue(3'd1, 3'd5, SUB);
        chk("ill_dst_err", err, 1);
        chk("ill_dst_flag_z", flag_z, 1);
        exp_q.push_back(8'h00);
        issue(3'd1, 3'd0, MOVE);
        chk("legal_clears_err", err, 0);
        wait_idle();

        // Reset while waiting on OUT drops out_valid
        out_rdy = 1'b0;
        issue(3'd0, 3'd0, CLR);
        @(negedge clk);
        chk("wo_out_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("wo_rst_valid", out_valid, 0);
        rst = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);

        // Reset while waiting on IN aborts the command
        issue(3'd0, 3'd2, MOVE);
        chk("wi_in_ready", in_ready, 1);
        chk("wi_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("wi_rst_in_ready", in_ready, 0);
        chk("wi_rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wi_late_in_ready", in_ready, 0);
            chk("wi_late_busy", busy, 0);
        end
        in_valid = 1'b0;
        exp_q.push_back(8'h00);
        run(3'd2, 3'd0, MOVE, 1'b0, 8'h00);

        // CLEAR skips IN and clears carry
        run(3'd0, 3'd3, MOVE, 1'b1, 8'h9C);
        run(3'd3, 3'd3, ADD, 1'b0, 8'h00);
        chk("dbl_flag_c", flag_c, 1);
        exp_q.push_back(8'h38);
        run(3'd3, 3'd0, MOVE, 1'b0, 8'h00);
        run(3'd0, 3'd3, ADD, 1'b1, 8'hC8);
        chk("pre_clr_flag_c", flag_c, 1);
        issue(3'd0, 3'd3, CLR);
        chk("clr_in_ready0", in_ready, 0);
        chk("clr_busy", busy, 1);
        chk("clr_cmd_ready0", cmd_ready, 0);
        @(negedge clk);
        chk("clr_cmd_ready1", cmd_ready, 1);
        chk("clr_in_ready1", in_ready, 0);
        chk("clr_flag_z", flag_z, 1);
        chk("clr_flag_c", flag_c, 0);
        exp_q.push_back(8'h00);
        run(3'd3, 3'd0, MOVE, 1'b0, 8'h00);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout("scoreboard_drain");
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
